uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Serial UART transmitter for the clock/UART control path. Takes one byte per valid/ready
//  handshake and drives a framed stream on tx: start(0), DATA_BITS LSB-first, optional
//  parity, stop(1). Each bit lasts CLKS_PER_BIT clk cycles. The receive side uses the same
//  bit period: 5208 cycles at 50 MHz for 9600 baud.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk cycles per serial bit; legal range >= 2
//  DATA_BITS     8     payload bits per frame; legal range 5..9
// PORTS
//  clk       in   1          system clock; all logic on posedge
//  reset     in   1          synchronous, active-high reset
//  tx_data   in   DATA_BITS  byte to send; sampled only on the accept cycle
//  tx_valid  in   1          upstream has a byte
//  tx_ready  out  1          block can accept; high only in IDLE
//  tx        out  1          serial line, registered, idles high
//  tx_busy   out  1          frame in progress (= ~tx_ready)
//  tx_done   out  1          1-cycle pulse when the stop bit completes
// BEHAVIOUR
//  - Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0,
//    bit index=0.
//  - Reset mid-frame aborts the frame. On the next edge tx=1 and the FSM is in IDLE.
//    No tx_done pulse is issued.
//  - Accept = tx_valid & tx_ready at a posedge. On that edge tx_data loads the shift
//    register, tx goes 0 (start bit), and the FSM enters START.
//  - tx_valid while busy is ignored and not queued. tx_data changes after accept have no
//    effect.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - Bit counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 in each non-IDLE
//    state. On the terminal count it resets to 0, the next bit is driven, and the state
//    advances.
//  - DATA: LSB first. The shift register shifts right each bit. The bit index counts
//    0..DATA_BITS-1, and the FSM leaves DATA after index DATA_BITS-1 completes.
//  - STOP: tx=1 for CLKS_PER_BIT cycles. On its terminal count the FSM returns to IDLE,
//    tx_done=1 for that one cycle, and tx_ready is high from the next cycle.
//  - Frame length: from the accept edge to tx_ready re-assertion is
//    NBITS*CLKS_PER_BIT cycles, where NBITS = 10 (11 with parity) for DATA_BITS=8.
//  - Back-to-back: accepting in the first IDLE cycle gives start immediately after stop,
//    with no extra idle bit.
//  - tx is never driven from combinational logic. No glitches are allowed at bit
//    boundaries.
// CONFIGURATION
//  - UART_TX_PARITY_EN defined: a PARITY state follows DATA. The bit sent is even parity,
//    i.e. the XOR of the latched data bits, lasting CLKS_PER_BIT cycles.
//  - UART_TX_PARITY_EN undefined: DATA goes directly to STOP. No parity logic is
//    synthesised.
// STRUCTURE
//  - Shared package uart_pkg holds:
//    - state encodings ST_IDLE/ST_START/ST_DATA/ST_PARITY/ST_STOP;
//    - the default CLKS_PER_BIT (5208);
//    - the line levels LINE_IDLE=1 and LINE_START=0.
//  - uart_pkg is shared with the receive path.
//  - One sub-module, uart_baud_counter: the per-bit cycle counter with clear and enable
//    inputs and a terminal-count (bit_end) output. It is reusable by the receiver.
//  - FSM and shift register stay in this module.
// TESTING  (bench runs CLKS_PER_BIT=4, plus one run at 5208)
//  1. Reset, idle 20 cycles -> tx=1, tx_ready=1, tx_done=0 throughout.
//  2. Send 0x55 (no parity) -> tx holds each level 4 cycles: 0,1,0,1,0,1,0,1,0,1.
//     tx_done pulses at cycle 40 after accept; tx_ready returns at cycle 40.
//  3. Send 0xA7 with UART_TX_PARITY_EN -> 0,1,1,1,0,0,1,0,1, parity 1, stop 1.
//     44 cycles total. Also 0x55 gives parity 0.
//  4. tx_valid held high with 0x01 then 0x80 -> two frames, stop of frame 1 directly
//     followed by start of frame 2. Exactly 2 tx_done pulses.
//  5. Assert reset at cycle 18 of a 0x00 frame -> tx=1 next cycle, tx_ready=1, no
//     tx_done pulse. A following 0xFF frame is correct.
//  6. Change tx_data and pulse tx_valid mid-frame -> serialised bits unchanged, the
//     extra request is dropped.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   - uart_state_e : frame sequencing states (IDLE, START, DATA, PARITY, STOP)
//   - DEFAULT_CLKS_PER_BIT : bit period in clk cycles (50 MHz / 9600 baud)
//   - LINE_IDLE / LINE_START : serial line levels for idle/stop and start bits
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: per-bit cycle counter shared by the UART transmitter and
// receiver. Counts 0..CLKS_PER_BIT-1 while enabled and wraps to 0 on the
// terminal count.
//   clk     in  system clock, posedge
//   reset   in  synchronous, active-high reset
//   clear   in  force the count back to 0 (has priority over enable)
//   enable  in  advance the count this cycle
//   bit_end out high during the last cycle of a bit period (terminal count)
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // bit_end is only meaningful while counting, so a clear suppresses it.
  always_comb begin
    cnt_d   = cnt_q;
    bit_end = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        bit_end = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter. Accepts one word per valid/ready
// handshake and sends start(0), DATA_BITS LSB-first, optional even parity and
// stop(1), each bit lasting CLKS_PER_BIT clk cycles.
//   clk       in  system clock, posedge
//   reset     in  synchronous, active-high reset (aborts any frame)
//   tx_data   in  word to send, sampled on the accept cycle only
//   tx_valid  in  upstream has a word
//   tx_ready  out can accept (IDLE only)
//   tx        out registered serial line, idles high
//   tx_busy   out frame in progress (inverse of tx_ready)
//   tx_done   out one-cycle pulse after the stop bit completes
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// the data bits; without it no parity logic exists.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign accept   = tx_valid & tx_ready;

  // The counter idles at zero in IDLE so every frame starts on a full bit.
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (tx_ready),
    .enable (tx_busy),
    .bit_end(bit_end)
  );

  // Next-state logic. The line level for the following bit is computed here
  // and registered on the same edge as the state change, so tx switches
  // cleanly at bit boundaries. The shift register always presents the next
  // data bit at bit 0.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        tx_d = LINE_IDLE;
        if (accept) begin
          shift_d   = tx_data;
          bit_idx_d = '0;
          tx_d      = LINE_START;
          state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = LINE_IDLE;
            state_d = ST_STOP;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          tx_d    = LINE_IDLE;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          tx_d    = LINE_IDLE;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = LINE_IDLE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= LINE_IDLE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed self-checking bench for uart_tx_serializer.
// A fast instance (4 clk per bit) covers reset, framing, parity, back-to-back,
// mid-frame reset and ignored requests; a second instance at the default
// 5208 clk per bit checks one full frame. Define UART_TX_PARITY_EN for the
// parity build.
module tb_uart_tx_serializer;

  localparam int CPB      = 4;
  localparam int SLOW_CPB = 5208;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 10 + PAR;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx, tx_busy, tx_done;

  logic [7:0] slow_data;
  logic       slow_valid;
  logic       slow_ready, slow_tx, slow_busy, slow_done;

  int errors = 0;
  int checks = 0;
  int doneCount;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(SLOW_CPB), .DATA_BITS(8)) dut_slow (
    .clk     (clk),
    .reset   (reset),
    .tx_data (slow_data),
    .tx_valid(slow_valid),
    .tx_ready(slow_ready),
    .tx      (slow_tx),
    .tx_busy (slow_busy),
    .tx_done (slow_done)
  );

  // Expected line level for frame bit idx: start, 8 data LSB-first,
  // optional even parity, stop.
  function automatic logic frameBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR == 1 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    tx_valid = valid;
    tx_data  = data;
  endtask

  // Present a word for one accept edge; returns at the negedge after accept.
  task automatic startFrame(input string tag, input logic [7:0] data, input logic holdValid);
    checkOutput({tag, " ready before accept"}, tx_ready, 1'b1);
    applyStimulus(1'b1, data);
    @(negedge clk);
    if (!holdValid) applyStimulus(1'b0, data);
  endtask

  // Called at sample 0 (negedge after accept); checks every cycle through the
  // first IDLE cycle. With disturb set, tx_data is altered and tx_valid pulsed
  // in the middle of the frame.
  task automatic checkFrame(input string tag, input logic [7:0] data, input logic disturb);
    for (int s = 0; s < NBITS * CPB; s++) begin
      checkOutput($sformatf("%s tx s%0d", tag, s), tx, frameBit(data, s / CPB));
      if (s % CPB == 0) begin
        checkOutput($sformatf("%s ready s%0d", tag, s), tx_ready, 1'b0);
        checkOutput($sformatf("%s busy s%0d", tag, s), tx_busy, 1'b1);
      end
      if (tx_done) doneCount++;
      if (disturb && s == 3 * CPB + 1) applyStimulus(1'b1, ~data);
      if (disturb && s == 3 * CPB + 2) applyStimulus(1'b0, ~data);
      @(negedge clk);
    end
    checkOutput({tag, " done at end"}, tx_done, 1'b1);
    checkOutput({tag, " ready at end"}, tx_ready, 1'b1);
    checkOutput({tag, " busy at end"}, tx_busy, 1'b0);
    checkOutput({tag, " tx idle at end"}, tx, 1'b1);
    if (tx_done) doneCount++;
  endtask

  initial begin
    reset      = 1'b1;
    slow_valid = 1'b0;
    slow_data  = 8'h00;
    applyStimulus(1'b0, 8'h00);

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset tx", tx, 1'b1);
    checkOutput("reset ready", tx_ready, 1'b1);
    checkOutput("reset busy", tx_busy, 1'b0);
    checkOutput("reset done", tx_done, 1'b0);
    reset = 1'b0;

    // Idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle tx c%0d", i), tx, 1'b1);
      checkOutput($sformatf("idle ready c%0d", i), tx_ready, 1'b1);
      checkOutput($sformatf("idle done c%0d", i), tx_done, 1'b0);
    end

    // 0x55: alternating line, parity 0 when enabled
    doneCount = 0;
    startFrame("f55", 8'h55, 1'b0);
    checkFrame("f55", 8'h55, 1'b0);
    @(negedge clk);
    checkOutput("f55 done one cycle", tx_done, 1'b0);
    checkCount("f55 done pulses", doneCount, 1);

    // 0xA7: parity 1 when enabled
    doneCount = 0;
    startFrame("fA7", 8'hA7, 1'b0);
    checkFrame("fA7", 8'hA7, 1'b0);
    @(negedge clk);
    checkCount("fA7 done pulses", doneCount, 1);

    // Back-to-back with tx_valid held high: 0x01 then 0x80
    doneCount = 0;
    startFrame("b2b1", 8'h01, 1'b1);
    applyStimulus(1'b1, 8'h80);
    checkFrame("b2b1", 8'h01, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h80);
    checkFrame("b2b2", 8'h80, 1'b0);
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      if (tx_done) doneCount++;
      checkOutput($sformatf("b2b idle tx c%0d", i), tx, 1'b1);
    end
    checkCount("b2b done pulses", doneCount, 2);

    // Reset at cycle 18 of a 0x00 frame
    doneCount = 0;
    startFrame("rst00", 8'h00, 1'b0);
    for (int s = 0; s < 18; s++) begin
      checkOutput($sformatf("rst00 tx s%0d", s), tx, frameBit(8'h00, s / CPB));
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst00 tx after reset", tx, 1'b1);
    checkOutput("rst00 ready after reset", tx_ready, 1'b1);
    checkOutput("rst00 done after reset", tx_done, 1'b0);
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      if (tx_done) doneCount++;
      checkOutput($sformatf("rst00 idle tx c%0d", i), tx, 1'b1);
    end
    checkCount("rst00 no done pulse", doneCount, 0);

    doneCount = 0;
    startFrame("fFF", 8'hFF, 1'b0);
    checkFrame("fFF", 8'hFF, 1'b0);
    @(negedge clk);
    checkCount("fFF done pulses", doneCount, 1);

    // Mid-frame data change and request are ignored, not queued
    doneCount = 0;
    startFrame("dist", 8'h3C, 1'b0);
    checkFrame("dist", 8'h3C, 1'b1);
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (tx_done) doneCount++;
      checkOutput($sformatf("dist idle tx c%0d", i), tx, 1'b1);
      checkOutput($sformatf("dist idle ready c%0d", i), tx_ready, 1'b1);
    end
    checkCount("dist done pulses", doneCount, 1);

    // Default bit period: one 0xC5 frame on the slow instance
    doneCount = 0;
    checkOutput("slow ready before", slow_ready, 1'b1);
    slow_valid = 1'b1;
    slow_data  = 8'hC5;
    @(negedge clk);
    slow_valid = 1'b0;
    slow_data  = 8'h00;
    for (int s = 0; s < NBITS * SLOW_CPB; s++) begin
      if (s % SLOW_CPB == 0 || s % SLOW_CPB == SLOW_CPB / 2 || s % SLOW_CPB == SLOW_CPB - 1)
        checkOutput($sformatf("slow tx s%0d", s), slow_tx, frameBit(8'hC5, s / SLOW_CPB));
      if (slow_done) doneCount++;
      @(negedge clk);
    end
    checkOutput("slow done at end", slow_done, 1'b1);
    checkOutput("slow ready at end", slow_ready, 1'b1);
    checkOutput("slow tx at end", slow_tx, 1'b1);
    checkCount("slow done early", doneCount, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
